// File: rtl/ucount_prescaler.sv
// Programmable tick prescaler feeding the 16-bit up/down counter stage.
// Divides clk or a synchronized external tick by D+1, with one-shot stop on overflow.
module ucount_prescaler #(
  parameter int DIV_W  = 8,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              _areset,
  input  logic              enable,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              src_sel,
  input  logic              ext_tick,
  input  logic              _oneshot,
  input  logic              overflow,
  output logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic              div_err,
  output logic [PCNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;
  logic               sync1_q, sync2_q, prev_q;
  logic               step;

  // Rising edge of the synchronized external tick, or every cycle on the internal source.
  assign step = src_sel ? (sync2_q & ~prev_q) : 1'b1;

  // NOTE: every register uses non-blocking assignment so all state updates
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      sync1_q <= ext_tick;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    carry_d = 1'b0;
    err_d   = div_load && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (div_load) div_d = div_val;
        if (enable) begin
          state_d = S_RUN;
          cnt_d   = div_load ? div_val : div_q;
          pcnt_d  = '0;
        end
      end
      S_RUN: begin
        // Dropping enable wins over the one-shot stop and swallows any due carry.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (carry_q && overflow && !_oneshot) begin
          state_d = S_DONE;
        end else if (step) begin
          if (cnt_q == '0) begin
            carry_d = 1'b1;
            cnt_d   = div_q;
            if (pcnt_q != '1) pcnt_d = pcnt_q + PCNT_W'(1);
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign carry_in  = carry_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign div_err   = err_q;
  assign pulse_cnt = pcnt_q;

endmodule
